// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared MIPS instruction/data memory: CPU has fixed
// priority, an aging counter guarantees DMA progress, fixed-latency reads are sequenced.

module mem_arbiter_chk (
  input logic        clk,
  input logic        reset,
  input logic        c_req,
  input logic        c_we,
  input logic [31:0] c_adr,
  input logic [31:0] c_wd,
  input logic        c_gnt,
  input logic        d_req,
  input logic        d_we,
  input logic [31:0] d_adr,
  input logic [31:0] d_wd,
  input logic        d_gnt
);
  // A waiting requester either withdraws or holds its request group unchanged.
  a_c_hold: assert property (@(posedge clk) disable iff (reset)
    (c_req && !c_gnt) |=> (!c_req || ($stable(c_we) && $stable(c_adr) && $stable(c_wd))));
  a_d_hold: assert property (@(posedge clk) disable iff (reset)
    (d_req && !d_gnt) |=> (!d_req || ($stable(d_we) && $stable(d_adr) && $stable(d_wd))));
  a_one_gnt: assert property (@(posedge clk) !(c_gnt && d_gnt));
endmodule

module mem_arbiter #(
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_adr,
  input  logic [31:0] c_wd,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wd,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rd,
  output logic        busy
);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [2:0]        RD_LOAD    = 3'(RD_LAT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RD_WAIT = 1'b1} state_t;
  typedef enum logic {OWN_C = 1'b0, OWN_D = 1'b1} owner_t;

  state_t             r_state, w_state_nxt;
  owner_t             r_owner, w_owner_nxt;
  logic [2:0]         r_rd_cnt, w_rd_cnt_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
  logic               w_c_win, w_d_win, w_we, w_re, w_capture;
  logic               r_c_rvalid, r_d_rvalid;
  logic [31:0]        r_c_rdata, r_d_rdata;
  logic [31:0]        w_adr, w_wd;

  // Winner selection: aged DMA, then CPU, then DMA; nothing outside IDLE or in reset.
  always_comb begin
    w_c_win = 1'b0;
    w_d_win = 1'b0;
    if (!reset && r_state == ST_IDLE) begin
      if (d_req && r_wait_cnt == MAX_WAIT_C) w_d_win = 1'b1;
      else if (c_req)                        w_c_win = 1'b1;
      else if (d_req)                        w_d_win = 1'b1;
      else                                   w_d_win = 1'b0;
    end else begin
      w_c_win = 1'b0;
    end
  end

  // Memory request mux driven from the winner's request group.
  always_comb begin
    w_adr = 32'd0;
    w_wd  = 32'd0;
    w_we  = 1'b0;
    w_re  = 1'b0;
    if (w_c_win) begin
      w_adr = c_adr;
      w_wd  = c_wd;
      w_we  = c_we;
      w_re  = ~c_we;
    end else if (w_d_win) begin
      w_adr = d_adr;
      w_wd  = d_wd;
      w_we  = d_we;
      w_re  = ~d_we;
    end else begin
      w_adr = 32'd0;
    end
  end

  assign w_capture = (r_state == ST_RD_WAIT) && (r_rd_cnt == 3'd0);

  // Read sequencing FSM next state.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rd_cnt_nxt = r_rd_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_re) begin
          w_state_nxt  = ST_RD_WAIT;
          w_owner_nxt  = w_d_win ? OWN_D : OWN_C;
          w_rd_cnt_nxt = RD_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (r_rd_cnt == 3'd0) w_state_nxt = ST_IDLE;
        else                  w_rd_cnt_nxt = r_rd_cnt - 3'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // DMA aging: count denied request cycles, saturating; clear on grant or withdrawal.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!d_req || w_d_win)              w_wait_nxt = {WAIT_W{1'b0}};
    else if (r_wait_cnt != MAX_WAIT_C)  w_wait_nxt = r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
    else                                w_wait_nxt = r_wait_cnt;
  end

  // State, counters and registered read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_C;
      r_rd_cnt   <= 3'd0;
      r_wait_cnt <= {WAIT_W{1'b0}};
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_c_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_c_rvalid <= w_capture && (r_owner == OWN_C);
      r_d_rvalid <= w_capture && (r_owner == OWN_D);
      if (w_capture && r_owner == OWN_C) r_c_rdata <= mem_rd;
      if (w_capture && r_owner == OWN_D) r_d_rdata <= mem_rd;
    end
  end

  assign c_gnt    = w_c_win;
  assign d_gnt    = w_d_win;
  assign mem_adr  = w_adr;
  assign mem_wd   = w_wd;
  assign mem_we   = w_we;
  assign mem_re   = w_re;
  assign busy     = (r_state == ST_RD_WAIT);
  assign c_rvalid = r_c_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign c_rdata  = r_c_rdata;
  assign d_rdata  = r_d_rdata;

  mem_arbiter_chk u_chk (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd), .c_gnt(w_c_win),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd), .d_gnt(w_d_win)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against
// a cycle-level reference model and a behavioural memory.

module tb_mem_arbiter;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 4;

  logic        clk, reset;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [31:0] c_adr, c_wd, c_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_adr, d_wd, d_rdata;
  logic [31:0] mem_adr, mem_wd, mem_rd;
  logic        mem_we, mem_re, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rd(mem_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: returns data exactly RD_LAT cycles after mem_re, junk otherwise.
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rd_pipe [int];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction
  function automatic logic [31:0] dev_get(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  initial mem_rd = 32'd0;
  always @(negedge clk) begin
    if (rd_pipe.exists(cyc)) begin
      mem_rd = rd_pipe[cyc];
      rd_pipe.delete(cyc);
    end else begin
      mem_rd = $urandom;
    end
    if (mem_re === 1'b1) rd_pipe[cyc + RD_LAT] = dev_get(mem_adr);
    if (mem_we === 1'b1) dev_mem[mem_adr] = mem_wd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    c_req = 1'b0;
    d_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    c_req = 1'b1; c_we = 1'b1; c_adr = 32'h200; c_wd = 32'h1111_1111;
    d_req = 1'b0; d_we = 1'b0; d_adr = 32'd0; d_wd = 32'd0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt, mem_we, mem_re, busy} !== 5'b0) begin
        errors++;
        $display("FAIL reset_strobes[%0d]: gnt/we/re/busy=%b want 00000", i, {c_gnt, d_gnt, mem_we, mem_re, busy});
      end
      checks++;
      if ({c_rvalid, d_rvalid} !== 2'b00 || c_rdata !== 32'd0 || d_rdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_rdata[%0d]: rv=%b c=%h d=%h want 0", i, {c_rvalid, d_rvalid}, c_rdata, d_rdata);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || mem_we !== 1'b1 || mem_adr !== 32'h200) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b we=%b adr=%h want 1 1 200", c_gnt, mem_we, mem_adr);
    end
    tick();
    idle(2);
  endtask

  task automatic test_cpu_read();
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h40;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_adr !== 32'h40 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_grant: gnt=%b re=%b we=%b adr=%h busy=%b", c_gnt, mem_re, mem_we, mem_adr, busy);
    end
    tick();
    c_req = 1'b0;
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || c_rvalid !== 1'b0 || mem_re !== 1'b0) begin
        errors++;
        $display("FAIL cpu_read_wait[%0d]: busy=%b rvalid=%b re=%b want 1 0 0", k, busy, c_rvalid, mem_re);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_return: rv=%b data=%h drv=%b busy=%b want 1 deadbeef 0 0", c_rvalid, c_rdata, d_rvalid, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_read_pulse: rv=%b data=%h want 0 deadbeef", c_rvalid, c_rdata);
    end
    tick();
    idle(1);
  endtask

  task automatic test_write_stream();
    d_req = 1'b1; d_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_adr = 32'h100 + 32'(4 * i);
      d_wd  = $urandom;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || c_gnt !== 1'b0 || mem_we !== 1'b1 || mem_re !== 1'b0) begin
        errors++;
        $display("FAIL wr_stream_strobe[%0d]: dgnt=%b cgnt=%b we=%b re=%b", i, d_gnt, c_gnt, mem_we, mem_re);
      end
      checks++;
      if (mem_adr !== d_adr || mem_wd !== d_wd) begin
        errors++;
        $display("FAIL wr_stream_data[%0d]: adr=%h wd=%h want %h %h", i, mem_adr, mem_wd, d_adr, d_wd);
      end
      tick();
    end
    idle(1);
  endtask

  task automatic test_aging();
    logic exp_d;
    c_req = 1'b1; c_we = 1'b1; c_adr = 32'h300; c_wd = 32'hC0C0_C0C0;
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h304; d_wd = 32'hD0D0_D0D0;
    for (int k = 0; k < 2 * MAX_WAIT + 2; k++) begin
      exp_d = (k == MAX_WAIT) || (k == 2 * MAX_WAIT + 1);
      @(negedge clk);
      checks++;
      if (d_gnt !== exp_d || c_gnt !== !exp_d || mem_adr !== (exp_d ? d_adr : c_adr)) begin
        errors++;
        $display("FAIL aging[%0d]: cgnt=%b dgnt=%b adr=%h want dgnt=%b", k, c_gnt, d_gnt, mem_adr, exp_d);
      end
      tick();
      if (exp_d) d_adr = d_adr + 32'd4;
    end
    idle(1);
  endtask

  task automatic test_read_blocks();
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h400; d_wd = 32'h1234_5678;
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      checks++;
      if (k == 0 && (c_gnt !== 1'b1 || d_gnt !== 1'b0)) begin
        errors++;
        $display("FAIL rd_block_grant: cgnt=%b dgnt=%b want 1 0", c_gnt, d_gnt);
      end else if (k > 0 && k <= RD_LAT && (d_gnt !== 1'b0 || c_gnt !== 1'b0)) begin
        errors++;
        $display("FAIL rd_block_wait[%0d]: cgnt=%b dgnt=%b want 0 0", k, c_gnt, d_gnt);
      end else if (k == RD_LAT + 1 && (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_adr !== 32'h400
                                        || c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF)) begin
        errors++;
        $display("FAIL rd_block_release: dgnt=%b we=%b adr=%h rv=%b data=%h", d_gnt, mem_we, mem_adr, c_rvalid, c_rdata);
      end
      tick();
      c_req = 1'b0;
    end
    idle(1);
  endtask

  task automatic test_reset_mid_read();
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h44;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || mem_re !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: gnt=%b re=%b want 1 1", c_gnt, mem_re);
    end
    tick();
    c_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h500; d_wd = 32'hABCD_0001;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || d_gnt !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b dgnt=%b we=%b want 0 1 1", busy, d_gnt, mem_we);
    end
    tick();
    d_req = 1'b0;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      @(negedge clk);
      checks++;
      if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || c_rdata !== 32'd0) begin
        errors++;
        $display("FAIL midrst_no_return[%0d]: crv=%b drv=%b cdata=%h want 0 0 0", k, c_rvalid, d_rvalid, c_rdata);
      end
      tick();
    end
    idle(1);
  endtask

  typedef struct {
    int          when;
    bit          own_d;
    logic [31:0] data;
  } ret_t;

  task automatic test_random();
    ret_t        q[$];
    bit          c_pend = 1'b0, d_pend = 1'b0, eg_c, eg_d, ex_we, ex_re, ex_crv, ex_drv;
    int          busy_left = 0, age = 0;
    logic [31:0] ex_adr, ex_wd, ex_crd = 32'd0, ex_drd = 32'd0;
    for (int n = 0; n < 800; n++) begin
      if (!c_pend && $urandom_range(0, 99) < 40) begin
        c_pend = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_adr = 32'h800 + ($urandom_range(0, 7) << 2); c_wd = $urandom;
      end else if (c_pend && $urandom_range(0, 99) < 5) begin
        c_pend = 1'b0;
      end
      if (!d_pend && $urandom_range(0, 99) < 50) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_adr = 32'h800 + ($urandom_range(0, 7) << 2); d_wd = $urandom;
      end else if (d_pend && $urandom_range(0, 99) < 5) begin
        d_pend = 1'b0;
      end
      c_req = c_pend;
      d_req = d_pend;
      @(negedge clk);
      eg_c = 1'b0; eg_d = 1'b0;
      if (busy_left == 0) begin
        if (d_req && age >= MAX_WAIT) eg_d = 1'b1;
        else if (c_req)               eg_c = 1'b1;
        else if (d_req)               eg_d = 1'b1;
      end
      ex_we  = (eg_c && c_we) || (eg_d && d_we);
      ex_re  = (eg_c && !c_we) || (eg_d && !d_we);
      ex_adr = eg_c ? c_adr : (eg_d ? d_adr : 32'd0);
      ex_wd  = eg_c ? c_wd : d_wd;
      ex_crv = 1'b0; ex_drv = 1'b0;
      if (q.size() > 0 && q[0].when == cyc) begin
        if (q[0].own_d) begin ex_drv = 1'b1; ex_drd = q[0].data; end
        else begin ex_crv = 1'b1; ex_crd = q[0].data; end
        void'(q.pop_front());
      end
      checks++;
      if (c_gnt !== eg_c || d_gnt !== eg_d || mem_we !== ex_we || mem_re !== ex_re || busy !== (busy_left > 0)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: cg/dg/we/re/busy=%b want %b", n, {c_gnt, d_gnt, mem_we, mem_re, busy},
                 {eg_c, eg_d, ex_we, ex_re, busy_left > 0});
      end
      checks++;
      if (mem_adr !== ex_adr || (ex_we && mem_wd !== ex_wd)) begin
        errors++;
        $display("FAIL rand_bus[%0d]: adr=%h wd=%h want %h %h", n, mem_adr, mem_wd, ex_adr, ex_wd);
      end
      checks++;
      if (c_rvalid !== ex_crv || d_rvalid !== ex_drv || c_rdata !== ex_crd || d_rdata !== ex_drd) begin
        errors++;
        $display("FAIL rand_ret[%0d]: rv=%b%b c=%h d=%h want %b%b %h %h", n, c_rvalid, d_rvalid, c_rdata, d_rdata,
                 ex_crv, ex_drv, ex_crd, ex_drd);
      end
      if (ex_we) ref_mem[ex_adr] = ex_wd;
      if (ex_re) begin
        q.push_back('{cyc + RD_LAT + 1, eg_d, ref_get(ex_adr)});
        busy_left = RD_LAT;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      age = (d_req && !eg_d) ? ((age < MAX_WAIT) ? age + 1 : MAX_WAIT) : 0;
      if (eg_c) c_pend = 1'b0;
      if (eg_d) d_pend = 1'b0;
      tick();
    end
    idle(RD_LAT + 2);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_stream();
    test_aging();
    test_read_blocks();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: port C (CPU) and port D (DMA/loader). It serialises accesses and sequences fixed-latency reads. Each granted read is returned to its owner with a registered rdata/rvalid pair. CPU has fixed priority, with an aging counter that guarantees DMA progress.

Parameters:
RD_LAT, 2, memory read latency in cycles from mem_re to valid mem_rd (legal range 1..7)
MAX_WAIT, 4, cycles DMA may be denied before it wins priority (legal range 1..2^WAIT_W-1)
WAIT_W, 4, width of the DMA aging counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
c_req  in  1  CPU request; c_we/c_adr/c_wd held stable until c_gnt
c_we  in  1  CPU write (1) / read (0)
c_adr  in  32  CPU byte address
c_wd  in  32  CPU write data
c_gnt  out  1  CPU request accepted this cycle (combinational)
c_rvalid  out  1  CPU read data valid, one-cycle pulse
c_rdata  out  32  CPU read data (registered)
d_req, d_we, d_adr[31:0], d_wd[31:0]  in  DMA request group; same rules as CPU
d_gnt  out  1  DMA request accepted this cycle
d_rvalid  out  1  DMA read data valid pulse
d_rdata  out  32  DMA read data (registered)
mem_adr  out  32  memory address (from winner; 0 when idle)
mem_wd  out  32  memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_rd  in  32  memory read data, valid RD_LAT cycles after mem_re
busy  out  1  read in flight (state RD_WAIT)

Behaviour:
- Clock and reset: one clock clk; reset is synchronous, active-high. While reset is sampled high, at that edge: state=IDLE, wait_cnt=0, rd_cnt=0, owner=C, c/d_rvalid=0, c/d_rdata=0. Outputs c_gnt, d_gnt, mem_we, mem_re, and busy are 0 in the first cycle after reset.
- States: IDLE, RD_WAIT.
- IDLE arbitration, combinational within the cycle:
  - If d_req and wait_cnt==MAX_WAIT, D wins.
  - Else if c_req, C wins.
  - Else if d_req, D wins.
  - Otherwise there is no grant.
- The winner's gnt=1. mem_adr/mem_wd/mem_we/mem_re are driven from the winner's inputs. The loser's gnt=0.
- Write grant: mem_we=1 for exactly that cycle; the write is complete; the state stays IDLE. Back-to-back writes are allowed every cycle.
- Read grant at cycle T: mem_re=1 at T; owner is recorded; rd_cnt loads RD_LAT-1; next state is RD_WAIT.
- RD_WAIT:
  - No grants are issued; mem_we=mem_re=0; busy=1.
  - rd_cnt decrements each cycle.
  - In cycle T+RD_LAT, mem_rd is captured into the owner's rdata register; the state returns to IDLE.
- Read return: owner's rvalid=1 at cycle T+RD_LAT+1 for one cycle. The non-owner's rdata/rvalid are unchanged/0.
- Overlap with next grant: cycle T+RD_LAT+1 is IDLE, so a new grant may coincide with the rvalid pulse. Minimum read-to-read spacing is therefore RD_LAT+1 cycles.
- Aging (wait_cnt):
  - Increments, saturating at MAX_WAIT, every cycle d_req=1 and d_gnt=0, including RD_WAIT cycles.
  - Clears to 0 on d_gnt or when d_req=0.
- Simultaneous requests: CPU wins unless wait_cnt==MAX_WAIT.
- Reset during RD_WAIT: the read is abandoned and no rvalid is produced; late mem_rd is ignored.
- Protocol: a requester deasserting req before gnt is legal (the request is withdrawn). Changing the request group while req=1 and gnt=0 is illegal; this is checked by assertion.

Test Plan:
- Reset: reset=1 for 2 cycles with c_req=1 -> c_gnt=0, mem_we=mem_re=0, rvalid=0, rdata=0 throughout; first grant comes in the cycle after reset drops.
- CPU read (RD_LAT=2): c_req, c_we=0, c_adr=0x40 at T, memory returns 0xDEADBEEF at T+2 -> c_gnt=1 and mem_re=1 at T; busy at T+1..T+2; c_rvalid=1 and c_rdata=0xDEADBEEF at T+3; d_rvalid stays 0.
- Write streaming: d_req with 3 successive writes to 0x100/0x104/0x108, c_req=0 -> d_gnt and mem_we high 3 consecutive cycles, correct mem_adr/mem_wd each cycle.
- Contention and aging (MAX_WAIT=4): c_req held high doing writes, d_req high from T -> c_gnt at T..T+3; d_gnt at T+4; wait_cnt back to 0 at T+5; c_gnt resumes at T+5.
- Read blocks grants: CPU read at T with d_req write pending -> d_gnt=0 during T..T+2; d_gnt=1 at T+3, coinciding with c_rvalid.
- Reset mid-read: CPU read at T, reset=1 at T+1 -> no c_rvalid ever; state IDLE at T+2; mem_rd at T+2 ignored; c_rdata=0.
